// File: rtl/clk_pkg.sv
// Shared definitions for the multi-channel clock divider.
package clk_pkg;

  localparam int unsigned CNT_W_DEF = 32;
  localparam int unsigned NCH_MAX   = 8;
  localparam int unsigned CFG_CH_W  = 3;

  typedef enum logic [1:0] {
    RUN  = 2'd0,
    HELD = 2'd1,
    STEP = 2'd2
  } ch_state_e;

endpackage

// File: rtl/clk_div_ch.sv
// One divided-clock channel: half-period counter, toggle output and run/hold/step control.
module clk_div_ch
  import clk_pkg::*;
#(
  parameter int unsigned      CNT_W     = CNT_W_DEF,
  parameter logic [CNT_W-1:0] HALF_INIT = '0
) (
  input  logic             clk_board,
  input  logic             rst,
  input  logic             stop,
  input  logic             step,
  input  logic             sync,
  input  logic             cfg_wr,
  input  logic [CNT_W-1:0] cfg_half,
  output logic             clk_out,
  output logic             tick,
  output logic             step_busy
);

  ch_state_e        state;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] half;
  logic             counting;
  logic             term;

  // A config write restarts the half-period, so it swallows a coincident terminal count.
  assign counting = (state == STEP) || ((state == RUN) && !stop);
  assign term     = counting && !cfg_wr && (cnt == half);

  always_ff @(posedge clk_board) begin
    if (rst) begin
      state     <= RUN;
      cnt       <= '0;
      half      <= HALF_INIT;
      clk_out   <= 1'b0;
      tick      <= 1'b0;
      step_busy <= 1'b0;
    end else begin
      if (cfg_wr) half <= cfg_half;

      if (sync) begin
        // Phase realignment only; control state is left alone.
        cnt     <= '0;
        clk_out <= 1'b0;
        tick    <= 1'b0;
      end else begin
        tick <= term && !clk_out;

        if (term) begin
          cnt     <= '0;
          clk_out <= !clk_out;
        end else if (cfg_wr) begin
          cnt <= '0;
        end else if (counting) begin
          cnt <= cnt + CNT_W'(1);
        end

        case (state)
          RUN: begin
            if (stop) state <= HELD;
          end
          HELD: begin
            if (!stop) begin
              state <= RUN;
            end else if (step) begin
              state     <= STEP;
              step_busy <= 1'b1;
            end
          end
          STEP: begin
            // Releasing stop mid-step resumes free running; otherwise the falling edge ends the step.
            if (!stop) begin
              state     <= RUN;
              step_busy <= 1'b0;
            end else if (term && clk_out) begin
              state     <= HELD;
              step_busy <= 1'b0;
            end
          end
          default: begin
            state     <= RUN;
            step_busy <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: rtl/clk_gen.sv
// Bank of independent clock-divider channels sharing one config port and a global sync.
module clk_gen
  import clk_pkg::*;
#(
  parameter int unsigned            NCH      = 2,
  parameter int unsigned            CNT_W    = CNT_W_DEF,
  parameter logic [NCH*CNT_W-1:0]   DIV_INIT = {32'd49999, 32'd2499999}
) (
  input  logic                clk_board,
  input  logic                rst,
  input  logic [NCH-1:0]      stop,
  input  logic [NCH-1:0]      step,
  input  logic                sync,
  input  logic                cfg_we,
  input  logic [CFG_CH_W-1:0] cfg_ch,
  input  logic [CNT_W-1:0]    cfg_half,
  output logic [NCH-1:0]      clk_out,
  output logic [NCH-1:0]      tick,
  output logic [NCH-1:0]      step_busy
);

  logic [NCH-1:0] cfg_wr_c;

  for (genvar c = 0; c < int'(NCH); c++) begin : g_ch
    // Out-of-range channel numbers never match any instance and are dropped.
    assign cfg_wr_c[c] = cfg_we && (cfg_ch == CFG_CH_W'(c));

    clk_div_ch #(
      .CNT_W     (CNT_W),
      .HALF_INIT (DIV_INIT[c*CNT_W +: CNT_W])
    ) u_ch (
      .clk_board (clk_board),
      .rst       (rst),
      .stop      (stop[c]),
      .step      (step[c]),
      .sync      (sync),
      .cfg_wr    (cfg_wr_c[c]),
      .cfg_half  (cfg_half),
      .clk_out   (clk_out[c]),
      .tick      (tick[c]),
      .step_busy (step_busy[c])
    );
  end

endmodule

// File: tb/tb_clk_gen.sv
// Self-checking bench for clk_gen: directed scenarios plus random traffic against a behavioural model.
module tb_clk_gen;

  localparam int unsigned NCH   = 2;
  localparam int unsigned CNT_W = 8;

  logic             clk_board = 1'b0;
  logic             rst;
  logic [NCH-1:0]   stop;
  logic [NCH-1:0]   step;
  logic             sync;
  logic             cfg_we;
  logic [2:0]       cfg_ch;
  logic [CNT_W-1:0] cfg_half;
  logic [NCH-1:0]   clk_out;
  logic [NCH-1:0]   tick;
  logic [NCH-1:0]   step_busy;

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // Behavioural model: per-channel position within the half period plus mode flags.
  int         m_init [2] = '{3, 1};
  int         m_cnt  [2];
  int         m_half [2];
  logic [1:0] m_out;
  logic [1:0] m_tick;
  logic [1:0] m_held;
  logic [1:0] m_stepping;

  clk_gen #(
    .NCH      (NCH),
    .CNT_W    (CNT_W),
    .DIV_INIT ({8'd1, 8'd3})
  ) dut (
    .clk_board (clk_board),
    .rst       (rst),
    .stop      (stop),
    .step      (step),
    .sync      (sync),
    .cfg_we    (cfg_we),
    .cfg_ch    (cfg_ch),
    .cfg_half  (cfg_half),
    .clk_out   (clk_out),
    .tick      (tick),
    .step_busy (step_busy)
  );

  always #5 clk_board = ~clk_board;

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic model_edge();
    logic wr;
    logic en;
    logic fire;
    for (int c = 0; c < 2; c++) begin
      if (rst) begin
        m_cnt[c] = 0; m_half[c] = m_init[c];
        m_out[c] = 1'b0; m_tick[c] = 1'b0;
        m_held[c] = 1'b0; m_stepping[c] = 1'b0;
      end else begin
        wr   = cfg_we && (int'(cfg_ch) == c);
        en   = m_stepping[c] || (!m_held[c] && !stop[c]);
        fire = en && !wr && (m_cnt[c] == m_half[c]);
        if (wr) m_half[c] = int'(cfg_half);
        if (sync) begin
          m_cnt[c] = 0; m_out[c] = 1'b0; m_tick[c] = 1'b0;
        end else begin
          m_tick[c] = fire && !m_out[c];
          if (m_stepping[c]) begin
            if (!stop[c]) m_stepping[c] = 1'b0;
            else if (fire && m_out[c]) begin m_stepping[c] = 1'b0; m_held[c] = 1'b1; end
          end else if (m_held[c]) begin
            if (!stop[c]) m_held[c] = 1'b0;
            else if (step[c]) begin m_held[c] = 1'b0; m_stepping[c] = 1'b1; end
          end else if (stop[c]) begin
            m_held[c] = 1'b1;
          end
          if (fire) begin m_cnt[c] = 0; m_out[c] = !m_out[c]; end
          else if (wr) m_cnt[c] = 0;
          else if (en) m_cnt[c] = m_cnt[c] + 1;
        end
      end
    end
  endtask

  task automatic clk_cycle();
    @(posedge clk_board);
    model_edge();
    cyc++;
    #1;
    check("model_clk_out",   8'(clk_out),   8'(m_out));
    check("model_tick",      8'(tick),      8'(m_tick));
    check("model_step_busy", 8'(step_busy), 8'(m_stepping));
  endtask

  initial begin
    logic prev;
    logic found;

    rst = 1'b1; stop = '0; step = '0; sync = 1'b0;
    cfg_we = 1'b0; cfg_ch = '0; cfg_half = '0;
    repeat (3) clk_cycle();
    check("reset_clk_out",   8'(clk_out),   8'd0);
    check("reset_tick",      8'(tick),      8'd0);
    check("reset_step_busy", 8'(step_busy), 8'd0);

    // Free-running periods after reset release.
    rst = 1'b0;
    for (int i = 1; i <= 24; i++) begin
      clk_cycle();
      check("run_ch0_out",  8'(clk_out[0]), 8'((i / 4) % 2));
      check("run_ch0_tick", 8'(tick[0]),    8'(i % 8 == 4));
      check("run_ch1_out",  8'(clk_out[1]), 8'((i / 2) % 2));
      check("run_ch1_tick", 8'(tick[1]),    8'(i % 4 == 2));
    end

    // Hold ch0 at count 2, then resume.
    repeat (2) clk_cycle();
    stop = 2'b01;
    repeat (10) begin
      clk_cycle();
      check("hold_ch0_out", 8'(clk_out[0]), 8'd0);
    end
    stop = 2'b00;
    for (int j = 1; j <= 10; j++) begin
      clk_cycle();
      check("resume_ch0_out",  8'(clk_out[0]), 8'(j >= 3 && j <= 6));
      check("resume_ch0_tick", 8'(tick[0]),    8'(j == 3));
    end

    // Single step from hold.
    rst = 1'b1; stop = 2'b01;
    clk_cycle();
    rst = 1'b0;
    repeat (3) clk_cycle();
    step = 2'b01;
    clk_cycle();
    step = 2'b00;
    check("step_busy_start", 8'(step_busy[0]), 8'd1);
    for (int j = 1; j <= 11; j++) begin
      clk_cycle();
      check("step_busy", 8'(step_busy[0]), 8'(j < 8));
      check("step_out",  8'(clk_out[0]),   8'(j >= 4 && j < 8));
      check("step_tick", 8'(tick[0]),      8'(j == 4));
    end

    // Config write coincident with a ch1 terminal count.
    stop = 2'b00;
    found = 1'b0;
    for (int k = 0; k < 16 && !found; k++) begin
      if (m_cnt[1] == m_half[1]) found = 1'b1;
      else clk_cycle();
    end
    check("cfg_term_found", 8'(found), 8'd1);
    prev = clk_out[1];
    cfg_we = 1'b1; cfg_ch = 3'd1; cfg_half = 8'd0;
    clk_cycle();
    cfg_we = 1'b0;
    check("cfg_no_toggle", 8'(clk_out[1]), 8'(prev));
    repeat (4) begin
      prev = clk_out[1];
      clk_cycle();
      check("cfg_fast_toggle", 8'(clk_out[1]), 8'(!prev));
    end
    cfg_we = 1'b1; cfg_ch = 3'd5; cfg_half = 8'd7;
    clk_cycle();
    cfg_we = 1'b0;
    repeat (4) begin
      prev = clk_out[1];
      clk_cycle();
      check("cfg_bad_ch_toggle", 8'(clk_out[1]), 8'(!prev));
    end

    // Sync while ch0 is high.
    found = 1'b0;
    for (int k = 0; k < 32 && !found; k++) begin
      if (m_out[0]) found = 1'b1;
      else clk_cycle();
    end
    check("sync_high_found", 8'(found), 8'd1);
    sync = 1'b1;
    clk_cycle();
    sync = 1'b0;
    check("sync_clk_out", 8'(clk_out), 8'd0);
    for (int j = 1; j <= 4; j++) begin
      clk_cycle();
      check("sync_ch0_rise", 8'(clk_out[0]), 8'(j == 4));
    end

    // Reset during a step.
    stop = 2'b01;
    repeat (2) clk_cycle();
    step = 2'b01;
    clk_cycle();
    step = 2'b00;
    repeat (3) clk_cycle();
    check("abort_busy_before", 8'(step_busy[0]), 8'd1);
    rst = 1'b1;
    clk_cycle();
    check("abort_clk_out",   8'(clk_out),   8'd0);
    check("abort_tick",      8'(tick),      8'd0);
    check("abort_step_busy", 8'(step_busy), 8'd0);
    rst = 1'b0; stop = 2'b00;

    // Random traffic against the model.
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(15) == 0) stop[0] = ~stop[0];
      if ($urandom_range(15) == 0) stop[1] = ~stop[1];
      step     = ($urandom_range(3) == 0) ? 2'($urandom_range(3)) : 2'b00;
      sync     = ($urandom_range(63) == 0);
      cfg_we   = ($urandom_range(31) == 0);
      cfg_ch   = 3'($urandom_range(7));
      cfg_half = 8'($urandom_range(5));
      rst      = ($urandom_range(255) == 0);
      clk_cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
